max_pool: RTL and testbench
===========================

MAX_POOL -- requirements
Module: max_pool

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1: begin pooling when sampled high in IDLE.
REQ-004 SHALL have port finish, output, 1: high while in DONE/IDLE after a completed run.
REQ-005 SHALL have ports M1_R_req and M2_R_req, output, 1: read request to feature-map memories 1 and 2.
REQ-006 SHALL have ports M1_addr and M2_addr, output, 32: word address.
REQ-007 SHALL have ports M1_R_data and M2_R_data, input, 32: read data, 4 signed int8 bytes, byte0 in [31:24].
REQ-008 SHALL have ports M1_W_req and M2_W_req, output, 4, tied 0; M1_W_data and M2_W_data, output, 32, tied 0.
REQ-009 SHALL have port M3_R_req, output, 1, tied 0; M3_addr, output, 32: word address of pooled-output memory.
REQ-010 SHALL have port M3_W_req, output, 4: byte write strobe, bit3 = bits [31:24] (byte offset 0).
REQ-011 SHALL have port M3_W_data, output, 32: write byte replicated into all four lanes.

Function
REQ-012 SHALL consume two 26x26 signed int8 maps, row-major, packed 4 bytes/word (676 bytes = 169 words each).
REQ-013 SHALL produce two 13x13 maps: out[r][c] = signed max of in[2r][2c], in[2r][2c+1], in[2r+1][2c], in[2r+1][2c+1].
REQ-014 SHALL place map1 pooled byte p = 13r+c at M3 byte address p and map2 at byte 169+p; word = byte>>2, lane = byte&3.
REQ-015 SHALL use states IDLE -> READ -> POOL -> NEXT -> (READ | DONE) -> IDLE.
REQ-016 IDLE: all request/strobe outputs 0; start=1 clears finish, sets r=0 and enters READ.
REQ-017 READ: issue M1/M2 reads to the same address 13r+k, k=0..12, one per cycle; memory data SHALL be sampled at the first rising edge after the edge that registered the address; 14 cycles total.
REQ-018 READ SHALL store the 52 bytes (rows 2r and 2r+1) of each map into two 52-byte buffers.
REQ-019 POOL: 26 cycles; even cycle 2c writes map1 out[r][c], odd cycle 2c+1 writes map2 out[r][c]; exactly one M3_W_req bit high per cycle.
REQ-020 NEXT: r increments; r==13 -> DONE, else READ.
REQ-021 DONE: finish <= 1, return to IDLE; finish SHALL stay 1 until the next accepted start.
REQ-022 start while not in IDLE SHALL be ignored; start held high after DONE SHALL re-run from r=0.
REQ-023 Comparison SHALL be 8-bit two's-complement; ties pass the equal value; no saturation needed.
REQ-024 Total latency start-to-finish SHALL be 13*(14+26+1)+2 = 535 cycles.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, r=0, finish=0, all R_req/W_req=0, all addr/W_data=0.
REQ-026 Reset mid-run SHALL abort without further M3 writes; buffers need no reset.

Configuration
REQ-027 Macro MAX_POOL_RELU_EN defined: each pooled byte SHALL be max(value, 0) before writing.
REQ-028 Macro MAX_POOL_RELU_EN undefined: raw signed max SHALL be written, negatives preserved.

Verification
REQ-029 M1 all 0x05, M2 all 0xFB, start pulse -> 338 byte writes, M3 bytes 0..168 = 0x05, 169..337 = 0xFB (0x00 with RELU_EN), finish=1 at cycle 535.
REQ-030 M1 window row0/1 cols0/1 = {0x80,0x7F,0x01,0xFF} -> M3 byte0 = 0x7F (signed compare check).
REQ-031 M2 window all 0x90 except in[1][1]=0xF0 -> M3 byte169 = 0xF0 without RELU_EN, 0x00 with it.
REQ-032 M1 byte ramp value = (row+col)&0x7F -> out[r][c] = 2r+2c+2; byte 168 lands in word 42 lane 0 (M3_W_req=4'b1000), byte 169 in word 42 lane 1 (4'b0100).
REQ-033 rst asserted during row 5 POOL -> outputs zero same cycle, no further M3 writes; new start -> full correct run.
REQ-034 start held high for 600 cycles -> run completes, finish pulses 0->1, second run begins, no start accepted mid-run.

Source files
------------

// File: rtl/max_pool.sv
// max_pool: 2x2 / stride-2 signed max pooling of two 26x26 int8 feature maps
// into two 13x13 maps stored back-to-back in the output memory.
// Input maps are read two image rows (13 words) at a time into local buffers.
// Output bytes are then written one per cycle with a one-hot byte strobe.
// Optional feature: define MAX_POOL_RELU_EN to clamp every pooled byte at zero.
module max_pool (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic        M1_R_req,
  output logic        M2_R_req,
  output logic [31:0] M1_addr,
  output logic [31:0] M2_addr,
  input  logic [31:0] M1_R_data,
  input  logic [31:0] M2_R_data,
  output logic [3:0]  M1_W_req,
  output logic [3:0]  M2_W_req,
  output logic [31:0] M1_W_data,
  output logic [31:0] M2_W_data,
  output logic        M3_R_req,
  output logic [31:0] M3_addr,
  output logic [3:0]  M3_W_req,
  output logic [31:0] M3_W_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    POOL,
    NEXT,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  r_q, r_d;
  logic        finish_q, finish_d;
  logic        rd_req_q, rd_req_d;
  logic [31:0] rd_addr_q, rd_addr_d;

  // Row-pair buffers: word k holds bytes 4k..4k+3 of rows 2r and 2r+1
  logic [12:0][31:0] buf1_q;
  logic [12:0][31:0] buf2_q;
  logic              buf_we;
  logic [3:0]        buf_idx;

  logic [31:0] row_base;
  logic [3:0]  pool_col;
  logic        pool_map;
  logic [12:0][31:0] pool_buf;
  logic [5:0]  j0, j1, j2, j3;
  logic [7:0]  pooled;
  logic [8:0]  out_byte;

  // Signed byte compare; on a tie either operand is the same value
  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Fetch byte j (0..51) of a row-pair buffer; byte 0 of a word is bits [31:24]
  function automatic logic [7:0] pick(input logic [12:0][31:0] b, input logic [5:0] j);
    return b[j[5:2]][{~j[1:0], 3'b000} +: 8];
  endfunction

  assign row_base = 32'(r_q) * 32'd13;

  // State and read-port registers; reset abandons any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      r_q       <= 4'd0;
      finish_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      finish_q  <= finish_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Capture the word whose address was registered one edge earlier
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf1_q[buf_idx] <= M1_R_data;
      buf2_q[buf_idx] <= M2_R_data;
    end
  end

  // Sequencing: READ issues 13 addresses then waits one cycle for the last
  // word, POOL emits 26 bytes, NEXT advances the row pair
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    finish_d  = finish_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    buf_we    = 1'b0;
    buf_idx   = cnt_q[3:0];
    case (state_q)
      IDLE: begin
        rd_req_d = 1'b0;
        if (start) begin
          finish_d  = 1'b0;
          r_d       = 4'd0;
          cnt_d     = 5'd0;
          rd_req_d  = 1'b1;
          rd_addr_d = 32'd0;
          state_d   = READ;
        end
      end
      READ: begin
        if (cnt_q <= 5'd12) begin
          buf_we = 1'b1;
        end
        if (cnt_q < 5'd12) begin
          rd_req_d  = 1'b1;
          rd_addr_d = row_base + 32'(cnt_q) + 32'd1;
        end else begin
          rd_req_d = 1'b0;
        end
        if (cnt_q == 5'd13) begin
          cnt_d   = 5'd0;
          state_d = POOL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      POOL: begin
        if (cnt_q == 5'd25) begin
          cnt_d   = 5'd0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      NEXT: begin
        r_d = r_q + 4'd1;
        if (r_q == 4'd12) begin
          state_d = DONE;
        end else begin
          rd_req_d  = 1'b1;
          rd_addr_d = (32'(r_q) + 32'd1) * 32'd13;
          state_d   = READ;
        end
      end
      DONE: begin
        finish_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pooling datapath: even POOL cycles serve map 1, odd cycles map 2
  always_comb begin
    pool_col = cnt_q[4:1];
    pool_map = cnt_q[0];
    pool_buf = pool_map ? buf2_q : buf1_q;
    j0       = {1'b0, pool_col, 1'b0};
    j1       = j0 + 6'd1;
    j2       = j0 + 6'd26;
    j3       = j0 + 6'd27;
    pooled   = smax(smax(pick(pool_buf, j0), pick(pool_buf, j1)),
                    smax(pick(pool_buf, j2), pick(pool_buf, j3)));
`ifdef MAX_POOL_RELU_EN
    if (pooled[7]) begin
      pooled = 8'd0;
    end
`endif
    out_byte = (pool_map ? 9'd169 : 9'd0) + 9'(r_q) * 9'd13 + 9'(pool_col);
  end

  // Output memory port is only active in POOL, so reset silences it at once
  always_comb begin
    M3_addr   = 32'd0;
    M3_W_req  = 4'b0000;
    M3_W_data = 32'd0;
    if (state_q == POOL) begin
      M3_addr   = {23'd0, out_byte[8:2]};
      M3_W_req  = 4'b1000 >> out_byte[1:0];
      M3_W_data = {4{pooled}};
    end
  end

  assign finish    = finish_q;
  assign M1_R_req  = rd_req_q;
  assign M2_R_req  = rd_req_q;
  assign M1_addr   = rd_addr_q;
  assign M2_addr   = rd_addr_q;
  assign M1_W_req  = 4'b0000;
  assign M2_W_req  = 4'b0000;
  assign M1_W_data = 32'd0;
  assign M2_W_data = 32'd0;
  assign M3_R_req  = 1'b0;

endmodule

// File: tb/tb_max_pool.sv
// tb_max_pool: scoreboard bench for max_pool; expected M3 writes are queued
// when input maps are loaded and popped as the design writes them.
module tb_max_pool;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        finish;
  logic        M1_R_req, M2_R_req;
  logic [31:0] M1_addr, M2_addr;
  logic [31:0] M1_R_data, M2_R_data;
  logic [3:0]  M1_W_req, M2_W_req;
  logic [31:0] M1_W_data, M2_W_data;
  logic        M3_R_req;
  logic [31:0] M3_addr;
  logic [3:0]  M3_W_req;
  logic [31:0] M3_W_data;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  logic [31:0] m1 [169];
  logic [31:0] m2 [169];
  logic [7:0]  m3 [340];
  logic [3:0]  strb_seen [340];
  logic [31:0] addr_seen [340];
  wr_t         exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          write_count = 0;

  max_pool dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .M1_R_req(M1_R_req), .M2_R_req(M2_R_req),
    .M1_addr(M1_addr), .M2_addr(M2_addr),
    .M1_R_data(M1_R_data), .M2_R_data(M2_R_data),
    .M1_W_req(M1_W_req), .M2_W_req(M2_W_req),
    .M1_W_data(M1_W_data), .M2_W_data(M2_W_data),
    .M3_R_req(M3_R_req), .M3_addr(M3_addr),
    .M3_W_req(M3_W_req), .M3_W_data(M3_W_data)
  );

  always #5 clk = ~clk;

  assign M1_R_data = (M1_addr < 32'd169) ? m1[M1_addr[7:0]] : 32'h0;
  assign M2_R_data = (M2_addr < 32'd169) ? m2[M2_addr[7:0]] : 32'h0;

  // Output memory model and scoreboard consumer
  always @(negedge clk) begin : monitor
    int  lane;
    int  b;
    wr_t e;
    if (!rst && M3_W_req != 4'b0000) begin
      write_count++;
      case (M3_W_req)
        4'b1000: lane = 0;
        4'b0100: lane = 1;
        4'b0010: lane = 2;
        4'b0001: lane = 3;
        default: lane = -1;
      endcase
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL m3_unexpected_write addr=%0d strb=%b data=%h, required no write",
                 M3_addr, M3_W_req, M3_W_data);
      end else begin
        e = exp_q.pop_front();
        if ({M3_addr, M3_W_req, M3_W_data} !== {e.addr, e.strb, e.data}) begin
          miscompares++;
          $display("[TB] FAIL m3_write got addr=%0d strb=%b data=%h, required addr=%0d strb=%b data=%h",
                   M3_addr, M3_W_req, M3_W_data, e.addr, e.strb, e.data);
        end
      end
      if (lane >= 0) begin
        b = int'(M3_addr) * 4 + lane;
        if (b < 340) begin
          m3[b]        = M3_W_data[(3 - lane) * 8 +: 8];
          strb_seen[b] = M3_W_req;
          addr_seen[b] = M3_addr;
        end
      end
    end
  end

  function automatic logic [7:0] in_byte(input int map, input int row, input int col);
    int b;
    logic [31:0] w;
    b = row * 26 + col;
    w = (map == 1) ? m2[b / 4] : m1[b / 4];
    return w[(3 - (b % 4)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] model_pool(input int map, input int r, input int c);
    int best;
    int v;
    best = -1000;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        v = int'($signed(in_byte(map, 2 * r + dr, 2 * c + dc)));
        if (v > best) best = v;
      end
    end
`ifdef MAX_POOL_RELU_EN
    if (best < 0) best = 0;
`endif
    return 8'(best);
  endfunction

  task automatic push_expected();
    wr_t e;
    int  b;
    logic [7:0] v;
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < 13; c++) begin
        for (int m = 0; m < 2; m++) begin
          b      = m * 169 + 13 * r + c;
          v      = model_pool(m, r, c);
          e.addr = 32'(b / 4);
          e.strb = 4'b1000 >> (b % 4);
          e.data = {4{v}};
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic set_byte(input int map, input int row, input int col, input logic [7:0] v);
    int b;
    b = row * 26 + col;
    if (map == 1) m2[b / 4][(3 - (b % 4)) * 8 +: 8] = v;
    else          m1[b / 4][(3 - (b % 4)) * 8 +: 8] = v;
  endtask

  task automatic clear_m3();
    for (int i = 0; i < 340; i++) begin
      m3[i]        = 8'hEE;
      strb_seen[i] = 4'b0000;
      addr_seen[i] = 32'hFFFF_FFFF;
    end
  endtask

  // Pulse start and count edges, the start-accepting edge being number 1
  task automatic run_pool(output int cycles);
    @(negedge clk);
    start  = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) start = 1'b0;
    end while (!(finish === 1'b1) && cycles < 2000);
    if (cycles >= 2000) begin
      miscompares++;
      $display("[TB] FAIL run_timeout cycles=%0d, required finish within 2000", cycles);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    #12;
    vectors++;
    if ({finish, M1_R_req, M2_R_req} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b, required 000", {finish, M1_R_req, M2_R_req});
    end
    vectors++;
    if ({M1_addr, M2_addr, M3_addr} !== 96'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr got %h %h %h, required 0", M1_addr, M2_addr, M3_addr);
    end
    vectors++;
    if ({M3_W_req, M3_W_data, M3_R_req} !== 37'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_m3 got strb=%b data=%h rreq=%b, required 0", M3_W_req, M3_W_data, M3_R_req);
    end
    vectors++;
    if ({M1_W_req, M2_W_req, M1_W_data, M2_W_data} !== 72'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_tied got %h, required 0", {M1_W_req, M2_W_req, M1_W_data, M2_W_data});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({finish, M1_R_req, M3_W_req} !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_start got %b, required 0", {finish, M1_R_req, M3_W_req});
    end
  endtask

  task automatic test_constant();
    int cycles;
    int bad1, bad2;
    logic [7:0] want2;
`ifdef MAX_POOL_RELU_EN
    want2 = 8'h00;
`else
    want2 = 8'hFB;
`endif
    for (int i = 0; i < 169; i++) begin
      m1[i] = 32'h0505_0505;
      m2[i] = 32'hFBFB_FBFB;
    end
    clear_m3();
    exp_q.delete();
    push_expected();
    write_count = 0;
    run_pool(cycles);
    vectors++;
    if (cycles != 535) begin
      miscompares++;
      $display("[TB] FAIL const_latency got %0d, required 535", cycles);
    end
    vectors++;
    if (write_count != 338) begin
      miscompares++;
      $display("[TB] FAIL const_write_count got %0d, required 338", write_count);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL const_queue_left got %0d, required 0", exp_q.size());
    end
    bad1 = 0;
    bad2 = 0;
    for (int i = 0; i < 169; i++) begin
      if (m3[i] !== 8'h05) bad1++;
      if (m3[169 + i] !== want2) bad2++;
    end
    vectors++;
    if (bad1 != 0) begin
      miscompares++;
      $display("[TB] FAIL const_map1 bad_bytes=%0d, required 0 (value 05)", bad1);
    end
    vectors++;
    if (bad2 != 0) begin
      miscompares++;
      $display("[TB] FAIL const_map2 bad_bytes=%0d, required 0 (value %h)", bad2, want2);
    end
    @(negedge clk);
    vectors++;
    if (finish !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL finish_held got %b, required 1", finish);
    end
  endtask

  task automatic test_signed();
    int cycles;
    logic [7:0] want169;
`ifdef MAX_POOL_RELU_EN
    want169 = 8'h00;
`else
    want169 = 8'hF0;
`endif
    for (int i = 0; i < 169; i++) begin
      m1[i] = $urandom;
      m2[i] = $urandom;
    end
    set_byte(0, 0, 0, 8'h80);
    set_byte(0, 0, 1, 8'h7F);
    set_byte(0, 1, 0, 8'h01);
    set_byte(0, 1, 1, 8'hFF);
    set_byte(1, 0, 0, 8'h90);
    set_byte(1, 0, 1, 8'h90);
    set_byte(1, 1, 0, 8'h90);
    set_byte(1, 1, 1, 8'hF0);
    clear_m3();
    exp_q.delete();
    push_expected();
    run_pool(cycles);
    vectors++;
    if (m3[0] !== 8'h7F) begin
      miscompares++;
      $display("[TB] FAIL signed_byte0 got %h, required 7f", m3[0]);
    end
    vectors++;
    if (m3[169] !== want169) begin
      miscompares++;
      $display("[TB] FAIL signed_byte169 got %h, required %h", m3[169], want169);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL signed_queue_left got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_ramp();
    int cycles;
    int bad;
    for (int i = 0; i < 169; i++) m2[i] = $urandom;
    for (int row = 0; row < 26; row++) begin
      for (int col = 0; col < 26; col++) begin
        set_byte(0, row, col, 8'((row + col) & 8'h7F));
      end
    end
    clear_m3();
    exp_q.delete();
    push_expected();
    run_pool(cycles);
    bad = 0;
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < 13; c++) begin
        if (m3[13 * r + c] !== 8'(2 * r + 2 * c + 2)) bad++;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL ramp_values bad_bytes=%0d, required 0", bad);
    end
    vectors++;
    if ({addr_seen[168], strb_seen[168]} !== {32'd42, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL ramp_byte168 got word=%0d strb=%b, required word=42 strb=1000",
               addr_seen[168], strb_seen[168]);
    end
    vectors++;
    if ({addr_seen[169], strb_seen[169]} !== {32'd42, 4'b0100}) begin
      miscompares++;
      $display("[TB] FAIL ramp_byte169 got word=%0d strb=%b, required word=42 strb=0100",
               addr_seen[169], strb_seen[169]);
    end
  endtask

  task automatic test_reset_midrun();
    int cycles;
    int wc;
    int i;
    for (int k = 0; k < 169; k++) begin
      m1[k] = $urandom;
      m2[k] = $urandom;
    end
    clear_m3();
    exp_q.delete();
    push_expected();
    write_count = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (write_count < 5 * 26 + 6 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (write_count < 5 * 26 + 6) begin
      miscompares++;
      $display("[TB] FAIL midrun_reach_row5 got %0d writes, required 136", write_count);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({M3_W_req, M3_W_data, M3_addr} !== 68'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_m3_zero got strb=%b data=%h addr=%h, required 0",
               M3_W_req, M3_W_data, M3_addr);
    end
    vectors++;
    if ({finish, M1_R_req, M2_R_req, M1_addr} !== 35'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_rd_zero got %h, required 0", {finish, M1_R_req, M2_R_req, M1_addr});
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wc = write_count;
    repeat (60) @(negedge clk);
    vectors++;
    if (write_count != wc) begin
      miscompares++;
      $display("[TB] FAIL midrun_no_writes got %0d extra, required 0", write_count - wc);
    end
    clear_m3();
    push_expected();
    write_count = 0;
    run_pool(cycles);
    vectors++;
    if (cycles != 535 || write_count != 338 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rerun_after_reset got cycles=%0d writes=%0d left=%0d, required 535 338 0",
               cycles, write_count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    int rise_at;
    int writes_at_rise;
    int fin_after;
    logic rreq_after;
    logic prev_fin;
    for (int k = 0; k < 169; k++) begin
      m1[k] = $urandom;
      m2[k] = $urandom;
    end
    exp_q.delete();
    push_expected();
    push_expected();
    write_count    = 0;
    rise_at        = -1;
    writes_at_rise = -1;
    fin_after      = -1;
    rreq_after     = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    prev_fin = 1'b0;
    for (cycles = 1; cycles <= 600; cycles++) begin
      @(posedge clk);
      #1;
      if (cycles == rise_at + 1 && rise_at > 0) begin
        fin_after  = int'(finish);
        rreq_after = M1_R_req;
      end
      if (finish === 1'b1 && prev_fin === 1'b0 && rise_at < 0) begin
        rise_at        = cycles;
        writes_at_rise = write_count;
      end
      prev_fin = finish;
    end
    start = 1'b0;
    vectors++;
    if (rise_at != 535) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_finish got %0d, required 535", rise_at);
    end
    vectors++;
    if (writes_at_rise != 338) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_writes got %0d, required 338", writes_at_rise);
    end
    vectors++;
    if (fin_after != 0 || rreq_after !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart got finish=%0d rreq=%b, required 0 1", fin_after, rreq_after);
    end
    cycles = 0;
    while (finish !== 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (finish !== 1'b1 || write_count != 676 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_run got finish=%b writes=%0d left=%0d, required 1 676 0",
               finish, write_count, exp_q.size());
    end
  endtask

  initial begin
    start = 1'b0;
    rst   = 1'b1;
    clear_m3();
    for (int i = 0; i < 169; i++) begin
      m1[i] = 32'd0;
      m2[i] = 32'd0;
    end
    $display("[TB] max_pool bench starting");
    test_reset();
    test_constant();
    test_signed();
    test_ramp();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
